rv_ctrl_hazard_pipe: RTL and testbench
======================================

# rv_ctrl_hazard_pipe

Parametrised pipelined control path for the 5-stage RV32I core. It decodes the Decode-stage instruction and carries control and register indices through the E/M/W pipeline registers. It also contains the hazard unit: load-use stall, branch/jump flush and E-stage operand forwarding. It supports the full conditional-branch set and a configurable ALU control width.

## Interface
- `ALUCTRL_W`, 4: ALUControl width.
  - 4 gives the full ALU op set.
  - 3 gives the reduced set (add/sub/and/or/xor/slt).
- `FULL_BRANCH`, 1: 1 = all six B-type conditions; 0 = only `beq` can be taken.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `InstrD` in 32: instruction in Decode.
- `ZeroE`, `NegE`, `CarryE`, `OvfE` in 1 each: ALU flags of the E-stage subtraction. `CarryE` = 1 means no borrow.
- `ImmSrcD` out 2: 00 I, 01 S, 10 B, 11 J.
- `ALUSrcE` out 1: 1 = immediate operand.
- `ALUControlE` out ALUCTRL_W.
- `PCSrcE` out 1: taken branch or jump.
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 01 W result, 10 M ALU result.
- `StallF`, `StallD`, `FlushD`, `FlushE` out 1 each.
- `MemWriteM`, `RegWriteM` out 1 each.
- `RegWriteW` out 1.
- `ResultSrcW` out 2: 00 ALU, 01 memory, 10 PC+4.
- `RdM`, `RdW` out 5.

## Operation
- **Decode.** Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, B 1100011, jal 1101111. Any other opcode decodes as a NOP: all enables 0, ImmSrc 00.
- **ALU ops, ALUCTRL_W=4.** add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001.
  - sub selected only when R-type and funct7[5]=1. I-type `addi` with funct7[5]=1 stays add.
  - sra selected when funct3=101 and funct7[5]=1, for both R-type and I-type.
- **ALU ops, ALUCTRL_W=3.** add 000, sub 001, and 010, or 011, xor 100, slt 101. Shifts and sltu decode to add (000).
- **Loads, stores, branches.** lw/sw use add. Branches use sub.
- **Branch decision**, taken when:
  - beq (funct3 000): Z
  - bne (001): !Z
  - blt (100): N^V
  - bge (101): !(N^V)
  - bltu (110): !C
  - bgeu (111): C
  - With FULL_BRANCH=0, only funct3 000 can be taken.
- **PCSrcE** = JumpE | (BranchE & cond).
- **Pipeline registers.**
  - D→E holds RegWrite, ResultSrc, MemWrite, Jump, Branch, funct3, ALUControl, ALUSrc, Rs1, Rs2, Rd.
  - E→M holds RegWrite, ResultSrc, MemWrite, Rd.
  - M→W holds RegWrite, ResultSrc, Rd.
- **Load-use stall.** lwStall = (ResultSrcE==01) & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE).
  - Rs1D = InstrD[19:15]; Rs2D = InstrD[24:20].
  - The rs2 compare is applied regardless of opcode; conservative stalls are allowed.
- **Stall/flush outputs.** StallF = StallD = lwStall. FlushD = PCSrcE. FlushE = lwStall | PCSrcE.
- **ForwardAE.**
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - M has priority over W.
- **ForwardBE.** Same rule using Rs2E.

## Timing
- **Reset.** On `reset` low, all pipeline registers clear asynchronously. Every registered output is 0: ALUSrcE, ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW.
  - As a result PCSrcE, FlushD, FlushE and Forward* are 0 and nothing is stalled.
  - Leaving reset is synchronous to the next rising edge.
- **Latency.** Control for an instruction in D appears at the E outputs 1 cycle later, at M after 2, at W after 3.
- **FlushE.** Synchronous clear of D→E on the next edge, producing a bubble.
  - Takes priority over all other D→E updates.
  - A flush in the same cycle as a stall still yields a bubble in E.
- **Other stages.** E→M and M→W never stall or flush. A bubble propagates as RegWrite=0 and MemWrite=0.
- **Combinational outputs.** lwStall, Forward* and PCSrcE are combinational from the current register state, InstrD and the flags, all within the same cycle. There is no path from InstrD to PCSrcE.
- **Branch penalty.** A taken branch or jump costs 2 cycles: the D and E instructions are flushed.
- **Register x0.** Rd=0 never triggers forwarding or a stall.

## Test plan
- **Reset.** Assert `reset`=0 mid-stream with RegWriteM=1 → all outputs 0 immediately (asynchronous). After release, one NOP edge keeps them 0.
- **Load-use stall.** `lw x5,0(x1)` followed by `add x6,x5,x2` → one cycle of StallF=StallD=FlushE=1. The add then enters E with ForwardAE=01 when the lw is in W.
- **Forward priority.** `add x3`, then `sub x3`, then `or x4,x3,x3` → in E, ForwardAE=ForwardBE=10 (M wins over W). With rd=x0 → 00.
- **Branches, FULL_BRANCH=1.**
  - bltu with C=0 → PCSrcE=1, FlushD=FlushE=1 for one cycle.
  - bge with N=1, V=1 → taken.
  - bne with Z=1 → not taken.
- **Reduced configuration.** FULL_BRANCH=0 with blt and N=1, V=0 → PCSrcE=0. ALUCTRL_W=3 with `srai` → ALUControlE=000, and with `sub` → 001.
- **jal.** jal x1 → ImmSrcD=11 in D. In E, PCSrcE=1. In W, ResultSrcW=10, RegWriteW=1, RdW=1.

Source files
------------

// File: rtl/rv_ctrl_hazard_pipe.sv
// Control path of the 5-stage RV32I pipeline: decode, E/M/W control registers,
// and the hazard unit (load-use stall, branch/jump flush, E-stage forwarding).
module rv_ctrl_hazard_pipe #(
  parameter int unsigned ALUCTRL_W   = 4,
  parameter bit          FULL_BRANCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic                 ZeroE,
  input  logic                 NegE,
  input  logic                 CarryE,
  input  logic                 OvfE,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 PCSrcE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdM,
  output logic [4:0]           RdW
);

  typedef enum logic [6:0] {
    OpLoad  = 7'b0000011,
    OpStore = 7'b0100011,
    OpReg   = 7'b0110011,
    OpImm   = 7'b0010011,
    OpBr    = 7'b1100011,
    OpJal   = 7'b1101111
  } opcodeT;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr  = 4'd3, AluXor  = 4'd4,
    AluSlt  = 4'd5, AluSll = 4'd6, AluSrl = 4'd7, AluSra = 4'd8, AluSltu = 4'd9
  } aluOpT;

  logic [2:0] funct3D;
  logic       f7b5D;
  logic [4:0] rs1D, rs2D, rdD;
  logic       unusedInstr;

  assign funct3D     = InstrD[14:12];
  assign f7b5D       = InstrD[30];
  assign rs1D        = InstrD[19:15];
  assign rs2D        = InstrD[24:20];
  assign rdD         = InstrD[11:7];
  assign unusedInstr = ^{InstrD[31], InstrD[29:25]};

  logic                 regWriteD, memWriteD, jumpD, branchD, aluSrcD, aluArithD;
  logic [1:0]           resultSrcD;
  aluOpT                aluOpD;
  logic [3:0]           aluCodeD;
  logic [ALUCTRL_W-1:0] aluControlD;

  always_comb begin
    regWriteD  = 1'b0;
    memWriteD  = 1'b0;
    jumpD      = 1'b0;
    branchD    = 1'b0;
    aluSrcD    = 1'b0;
    aluArithD  = 1'b0;
    resultSrcD = 2'b00;
    ImmSrcD    = 2'b00;
    aluOpD     = AluAdd;
    case (InstrD[6:0])
      OpLoad:  begin regWriteD = 1'b1; resultSrcD = 2'b01; aluSrcD = 1'b1; end
      OpStore: begin memWriteD = 1'b1; aluSrcD = 1'b1; ImmSrcD = 2'b01; end
      OpReg:   begin regWriteD = 1'b1; aluArithD = 1'b1; end
      OpImm:   begin regWriteD = 1'b1; aluArithD = 1'b1; aluSrcD = 1'b1; end
      OpBr:    begin branchD = 1'b1; ImmSrcD = 2'b10; aluOpD = AluSub; end
      OpJal:   begin regWriteD = 1'b1; jumpD = 1'b1; ImmSrcD = 2'b11; resultSrcD = 2'b10; end
      default: ;
    endcase
    if (aluArithD) begin
      // funct7[5] on an I-type only matters for srai; addi with it set is still add
      case (funct3D)
        3'b000:  aluOpD = (InstrD[6:0] == OpReg && f7b5D) ? AluSub : AluAdd;
        3'b001:  aluOpD = AluSll;
        3'b010:  aluOpD = AluSlt;
        3'b011:  aluOpD = AluSltu;
        3'b100:  aluOpD = AluXor;
        3'b101:  aluOpD = f7b5D ? AluSra : AluSrl;
        3'b110:  aluOpD = AluOr;
        default: aluOpD = AluAnd;
      endcase
    end
  end

  // The reduced ALU has no shifter or unsigned compare; those ops fall back to add.
  always_comb begin
    aluCodeD = aluOpD;
    if (ALUCTRL_W < 4 && aluOpD > AluSlt) aluCodeD = '0;
  end
  assign aluControlD = aluCodeD[ALUCTRL_W-1:0];

  logic       regWriteE, memWriteE, jumpE, branchE;
  logic [1:0] resultSrcE, resultSrcM;
  logic [2:0] funct3E;
  logic [4:0] rs1E, rs2E, rdE;
  logic       lwStall, branchCond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteE   <= 1'b0;
      resultSrcE  <= 2'b00;
      memWriteE   <= 1'b0;
      jumpE       <= 1'b0;
      branchE     <= 1'b0;
      funct3E     <= '0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
    end else if (FlushE) begin
      regWriteE   <= 1'b0;
      resultSrcE  <= 2'b00;
      memWriteE   <= 1'b0;
      jumpE       <= 1'b0;
      branchE     <= 1'b0;
      funct3E     <= '0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
    end else begin
      regWriteE   <= regWriteD;
      resultSrcE  <= resultSrcD;
      memWriteE   <= memWriteD;
      jumpE       <= jumpD;
      branchE     <= branchD;
      funct3E     <= funct3D;
      ALUControlE <= aluControlD;
      ALUSrcE     <= aluSrcD;
      rs1E        <= rs1D;
      rs2E        <= rs2D;
      rdE         <= rdD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      RdM        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= '0;
    end else begin
      RegWriteM  <= regWriteE;
      resultSrcM <= resultSrcE;
      MemWriteM  <= memWriteE;
      RdM        <= rdE;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= resultSrcM;
      RdW        <= RdM;
    end
  end

  // Flags come from rs1 - rs2; CarryE high means no borrow (rs1 >= rs2 unsigned).
  always_comb begin
    case (funct3E)
      3'b000:  branchCond = ZeroE;
      3'b001:  branchCond = !ZeroE;
      3'b100:  branchCond = NegE ^ OvfE;
      3'b101:  branchCond = !(NegE ^ OvfE);
      3'b110:  branchCond = !CarryE;
      3'b111:  branchCond = CarryE;
      default: branchCond = 1'b0;
    endcase
    if (!FULL_BRANCH && funct3E != 3'b000) branchCond = 1'b0;
  end

  assign PCSrcE  = jumpE | (branchE & branchCond);
  assign lwStall = (resultSrcE == 2'b01) && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
  assign StallF  = lwStall;
  assign StallD  = lwStall;
  assign FlushD  = PCSrcE;
  assign FlushE  = lwStall | PCSrcE;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == rs1E) ForwardAE = 2'b01;
    if (RegWriteM && RdM != '0 && RdM == rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == rs2E) ForwardBE = 2'b01;
  end

endmodule

// File: tb/tb_rv_ctrl_hazard_pipe.sv
// Bench for rv_ctrl_hazard_pipe: decode vector table, hand-written hazard sequences,
// and a randomized instruction stream checked against an instruction-level pipeline model.
module tb_rv_ctrl_hazard_pipe;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        ZeroE, NegE, CarryE, OvfE;

  logic [1:0] ImmSrcD, ForwardAE, ForwardBE, ResultSrcW;
  logic       ALUSrcE, PCSrcE, StallF, StallD, FlushD, FlushE, MemWriteM, RegWriteM, RegWriteW;
  logic [3:0] ALUControlE;
  logic [4:0] RdM, RdW;

  logic [1:0] rImmSrcD, rForwardAE, rForwardBE, rResultSrcW;
  logic       rALUSrcE, rPCSrcE, rStallF, rStallD, rFlushD, rFlushE, rMemWriteM, rRegWriteM, rRegWriteW;
  logic [2:0] rALUControlE;
  logic [4:0] rRdM, rRdW;

  always #5 clk = ~clk;

  rv_ctrl_hazard_pipe #(.ALUCTRL_W(4), .FULL_BRANCH(1'b1)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD),
    .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE), .OvfE(OvfE),
    .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdM(RdM), .RdW(RdW)
  );

  rv_ctrl_hazard_pipe #(.ALUCTRL_W(3), .FULL_BRANCH(1'b0)) dutR (
    .clk(clk), .reset(reset), .InstrD(InstrD),
    .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE), .OvfE(OvfE),
    .ImmSrcD(rImmSrcD), .ALUSrcE(rALUSrcE), .ALUControlE(rALUControlE), .PCSrcE(rPCSrcE),
    .ForwardAE(rForwardAE), .ForwardBE(rForwardBE), .StallF(rStallF), .StallD(rStallD),
    .FlushD(rFlushD), .FlushE(rFlushE), .MemWriteM(rMemWriteM), .RegWriteM(rRegWriteM),
    .RegWriteW(rRegWriteW), .ResultSrcW(rResultSrcW), .RdM(rRdM), .RdW(rRdW)
  );

  int unsigned nPass = 0, nTotal = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // ---------------- instruction-level reference model ----------------
  function automatic logic [4:0] rdOf(input logic [31:0] i);  return i[11:7];  endfunction
  function automatic logic [4:0] rs1Of(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] rs2Of(input logic [31:0] i); return i[24:20]; endfunction
  function automatic bit is(input logic [31:0] i, input logic [6:0] op); return i[6:0] == op; endfunction

  function automatic bit writesRd(input logic [31:0] i);
    return is(i, LW) || is(i, RT) || is(i, IT) || is(i, JAL);
  endfunction

  function automatic logic [1:0] resultSel(input logic [31:0] i);
    if (is(i, LW))  return 2'b01;
    if (is(i, JAL)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] immKind(input logic [31:0] i);
    if (is(i, SW))  return 2'b01;
    if (is(i, BR))  return 2'b10;
    if (is(i, JAL)) return 2'b11;
    return 2'b00;
  endfunction

  // ALU op named by its full-width code: add0 sub1 and2 or3 xor4 slt5 sll6 srl7 sra8 sltu9
  function automatic int aluOpOf(input logic [31:0] i);
    bit f7 = i[30];
    if (is(i, BR)) return 1;
    if (!(is(i, RT) || is(i, IT))) return 0;
    case (i[14:12])
      3'd0: return (is(i, RT) && f7) ? 1 : 0;
      3'd1: return 6;
      3'd2: return 5;
      3'd3: return 9;
      3'd4: return 4;
      3'd5: return f7 ? 8 : 7;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  // fl = {Z, N, C, V}
  function automatic bit taken(input logic [2:0] f3, input logic [3:0] fl);
    bit eq = fl[3], ltS = fl[2] != fl[0], ltU = !fl[1];
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return ltS;
      3'd5: return !ltS;
      3'd6: return ltU;
      3'd7: return !ltU;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [31:0] m, input logic [31:0] w);
    if (writesRd(m) && rdOf(m) != 0 && rdOf(m) == rs) return 2'b10;
    if (writesRd(w) && rdOf(w) != 0 && rdOf(w) == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mStall(input logic [31:0] d, input logic [31:0] e);
    return is(e, LW) && rdOf(e) != 0 && (rs1Of(d) == rdOf(e) || rs2Of(d) == rdOf(e));
  endfunction

  function automatic bit mPc(input logic [31:0] e, input logic [3:0] fl);
    return is(e, JAL) || (is(e, BR) && taken(e[14:12], fl));
  endfunction

  function automatic logic [63:0] expVec(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                                         input logic [31:0] w, input logic [3:0] fl);
    logic [63:0] v = '0;
    bit st = mStall(d, e), pc = mPc(e, fl);
    logic [3:0] alu = 4'(aluOpOf(e));
    v[30:0] = {immKind(d), is(e, LW) || is(e, SW) || is(e, IT), alu, pc,
               fwd(rs1Of(e), m, w), fwd(rs2Of(e), m, w), st, st, pc, st | pc,
               is(m, SW), writesRd(m), writesRd(w), resultSel(w), rdOf(m), rdOf(w)};
    return v;
  endfunction

  function automatic logic [63:0] actVec();
    logic [63:0] v = '0;
    v[30:0] = {ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, ForwardAE, ForwardBE, StallF, StallD,
               FlushD, FlushE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW};
    return v;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r = $urandom();
    logic [6:0]  f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    logic [4:0]  a = 5'($urandom_range(0, 3)), b = 5'($urandom_range(0, 3)), c = 5'($urandom_range(0, 3));
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: return enc(f7, b, a, f3, c, RT);
      1: return enc(f7, b, a, f3, c, IT);
      2: return enc(7'h00, b, a, 3'd2, c, LW);
      3: return enc(7'h00, b, a, 3'd2, c, SW);
      4: return enc(7'h00, b, a, f3, c, BR);
      5: return {r[31:12], c, JAL};
      6: return r;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  fl;
    logic [1:0]  imm;
    logic        src;
    logic [3:0]  alu;
    logic        pc;
    logic [2:0]  aluR;
    logic        pcR;
  } vecT;

  vecT tbl[22];

  task automatic step(input logic [31:0] instr);
    @(negedge clk);
    InstrD = instr;
    #1;
  endtask

  logic [31:0] eI, mI, wI, dI;
  logic [3:0]  fl;
  bit          st, pc, prevSt, prevPc;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{enc(7'h00, 2, 1, 0, 3, RT),  4'b0000, 2'b00, 0, 4'd0, 0, 3'd0, 0};
    tbl[1]  = '{enc(7'h20, 2, 1, 0, 3, RT),  4'b0000, 2'b00, 0, 4'd1, 0, 3'd1, 0};
    tbl[2]  = '{enc(7'h20, 3, 1, 5, 5, IT),  4'b0000, 2'b00, 1, 4'd8, 0, 3'd0, 0};
    tbl[3]  = '{enc(7'h20, 4, 1, 0, 5, IT),  4'b0000, 2'b00, 1, 4'd0, 0, 3'd0, 0};
    tbl[4]  = '{enc(7'h00, 2, 1, 3, 3, RT),  4'b0000, 2'b00, 0, 4'd9, 0, 3'd0, 0};
    tbl[5]  = '{enc(7'h00, 7, 1, 2, 3, IT),  4'b0000, 2'b00, 1, 4'd5, 0, 3'd5, 0};
    tbl[6]  = '{enc(7'h00, 2, 1, 7, 3, RT),  4'b0000, 2'b00, 0, 4'd2, 0, 3'd2, 0};
    tbl[7]  = '{enc(7'h00, 1, 1, 6, 3, IT),  4'b0000, 2'b00, 1, 4'd3, 0, 3'd3, 0};
    tbl[8]  = '{enc(7'h00, 2, 1, 4, 3, RT),  4'b0000, 2'b00, 0, 4'd4, 0, 3'd4, 0};
    tbl[9]  = '{enc(7'h00, 2, 1, 5, 3, RT),  4'b0000, 2'b00, 0, 4'd7, 0, 3'd0, 0};
    tbl[10] = '{enc(7'h00, 2, 1, 1, 3, IT),  4'b0000, 2'b00, 1, 4'd6, 0, 3'd0, 0};
    tbl[11] = '{enc(7'h00, 0, 1, 2, 5, LW),  4'b0000, 2'b00, 1, 4'd0, 0, 3'd0, 0};
    tbl[12] = '{enc(7'h00, 5, 1, 2, 4, SW),  4'b0000, 2'b01, 1, 4'd0, 0, 3'd0, 0};
    tbl[13] = '{enc(7'h00, 2, 1, 6, 0, BR),  4'b0000, 2'b10, 0, 4'd1, 1, 3'd1, 0};
    tbl[14] = '{enc(7'h00, 2, 1, 5, 0, BR),  4'b0101, 2'b10, 0, 4'd1, 1, 3'd1, 0};
    tbl[15] = '{enc(7'h00, 2, 1, 1, 0, BR),  4'b1010, 2'b10, 0, 4'd1, 0, 3'd1, 0};
    tbl[16] = '{enc(7'h00, 2, 1, 0, 0, BR),  4'b1000, 2'b10, 0, 4'd1, 1, 3'd1, 1};
    tbl[17] = '{enc(7'h00, 2, 1, 4, 0, BR),  4'b0100, 2'b10, 0, 4'd1, 1, 3'd1, 0};
    tbl[18] = '{{20'h00010, 5'd1, JAL},      4'b0000, 2'b11, 0, 4'd0, 1, 3'd0, 1};
    tbl[19] = '{enc(7'h00, 2, 1, 0, 3, 7'b0001111), 4'b0000, 2'b00, 0, 4'd0, 0, 3'd0, 0};
    tbl[20] = '{enc(7'h00, 2, 1, 7, 0, BR),  4'b0010, 2'b10, 0, 4'd1, 1, 3'd1, 0};
    tbl[21] = '{enc(7'h00, 2, 1, 0, 0, BR),  4'b0000, 2'b10, 0, 4'd1, 0, 3'd1, 0};

    reset = 1'b0; InstrD = '0; {ZeroE, NegE, CarryE, OvfE} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {ALUSrcE, ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW,
                          PCSrcE, FlushD, FlushE, StallF, StallD, ForwardAE, ForwardBE}, '0);
    @(negedge clk) reset = 1'b1;

    // decode table: instruction in D, then in E with its flags
    for (int i = 0; i < 22; i++) begin
      {ZeroE, NegE, CarryE, OvfE} = tbl[i].fl;
      step(tbl[i].instr);
      check($sformatf("imm[%0d]", i), ImmSrcD, tbl[i].imm);
      step(32'h0);
      check($sformatf("alusrc[%0d]", i), ALUSrcE, tbl[i].src);
      check($sformatf("alu[%0d]", i), ALUControlE, tbl[i].alu);
      check($sformatf("pcsrc[%0d]", i), {PCSrcE, FlushD, FlushE}, {3{tbl[i].pc}});
      check($sformatf("reduced[%0d]", i), {rALUControlE, rPCSrcE}, {tbl[i].aluR, tbl[i].pcR});
    end
    {ZeroE, NegE, CarryE, OvfE} = 4'b0000;

    // asynchronous reset mid-stream
    step(enc(7'h00, 2, 1, 0, 3, RT));
    step(32'h0);
    step(32'h0);
    check("regwriteM_before_reset", {RegWriteM, RdM}, {1'b1, 5'd3});
    #2 reset = 1'b0;
    #1;
    check("async_reset", {ALUSrcE, ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW,
                          PCSrcE, FlushD, FlushE, StallF, ForwardAE, ForwardBE}, '0);
    @(negedge clk) begin reset = 1'b1; InstrD = '0; end
    @(posedge clk);
    #1;
    check("after_reset_nop", {ALUSrcE, ALUControlE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW}, '0);

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    step(enc(7'h00, 0, 1, 2, 5, LW));
    step(enc(7'h00, 2, 5, 0, 6, RT));
    check("lwstall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    step(enc(7'h00, 2, 5, 0, 6, RT));
    check("lwstall_released", {StallF, StallD, FlushE, FlushD}, 4'b0000);
    step(32'h0);
    check("lw_fwd_from_W", {ForwardAE, ForwardBE}, 4'b0100);

    // forwarding priority M over W, then x0, then W-only
    step(32'h0); step(32'h0);
    step(enc(7'h00, 2, 1, 0, 3, RT));
    step(enc(7'h20, 2, 1, 0, 3, RT));
    step(enc(7'h00, 3, 3, 6, 4, RT));
    step(32'h0);
    check("fwd_m_priority", {ForwardAE, ForwardBE}, 4'b1010);
    step(enc(7'h00, 2, 1, 0, 0, RT));
    step(enc(7'h20, 2, 1, 0, 0, RT));
    step(enc(7'h00, 0, 0, 6, 4, RT));
    step(32'h0);
    check("fwd_x0", {ForwardAE, ForwardBE}, 4'b0000);
    step(enc(7'h00, 2, 1, 0, 7, RT));
    step(32'h0);
    step(enc(7'h00, 2, 7, 6, 4, RT));
    step(32'h0);
    check("fwd_w_only", {ForwardAE, ForwardBE}, 4'b0100);

    // jal x1 through the pipe
    step({20'h00020, 5'd1, JAL});
    check("jal_immsrc", ImmSrcD, 2'b11);
    step(32'h0);
    check("jal_pcsrc", {PCSrcE, FlushD, FlushE}, 3'b111);
    step(32'h0);
    step(32'h0);
    check("jal_writeback", {ResultSrcW, RegWriteW, RdW}, {2'b10, 1'b1, 5'd1});

    // randomized stream against the model; bench plays the F/D stage (hold on stall, bubble on flush)
    @(negedge clk) begin reset = 1'b0; InstrD = '0; end
    @(negedge clk) reset = 1'b1;
    eI = '0; mI = '0; wI = '0; dI = '0; prevSt = 0; prevPc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prevPc)       dI = 32'h0;
      else if (!prevSt) dI = randInstr();
      fl = 4'($urandom_range(0, 15));
      InstrD = dI;
      {ZeroE, NegE, CarryE, OvfE} = fl;
      #1;
      check($sformatf("random[%0d]", c), actVec(), expVec(dI, eI, mI, wI, fl));
      st = mStall(dI, eI);
      pc = mPc(eI, fl);
      @(posedge clk);
      wI = mI;
      mI = eI;
      eI = (st || pc) ? 32'h0 : dI;
      prevSt = st;
      prevPc = pc;
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
